mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 18 +
 rtl/mem_wait_cnt.sv | 35 +++
 rtl/mem_ctrl.sv | 161 ++++++++++++++++
 tb/tb_mem_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the CPU-to-memory access controller: FSM states,
// wait-counter width and the alignment helper.
package mem_ctrl_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        ERR    = 2'd3
    } state_e;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/mem_wait_cnt.sv
// Down-counter for memory wait states: loadable, counts down to zero and
// then holds there, flagging zero.
module mem_wait_cnt
    import mem_ctrl_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_ctrl.sv
// CPU-to-memory access controller with programmable wait states and
// misaligned-access trapping. Define MEM_CTRL_WBUF_EN for posted writes.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        cpu_stall,
    output logic        cpu_err,
    output logic [31:0] bad_addr,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] bad_q, bad_d;
    logic        wr_q, wr_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic        mem_wr_q, mem_wr_d;
    logic        cnt_load;
    logic        cnt_zero;
    logic        post_wr;
    logic        wbuf_busy;
    logic        post_en;

`ifdef MEM_CTRL_WBUF_EN
    // One-entry write buffer: busy for WAIT_CYCLES+1 cycles after a posted write.
    logic wbuf_busy_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            wbuf_busy_q <= 1'b0;
        end else if (post_wr) begin
            wbuf_busy_q <= 1'b1;
        end else if (cnt_zero) begin
            wbuf_busy_q <= 1'b0;
        end
    end

    assign wbuf_busy = wbuf_busy_q;
    assign post_en   = 1'b1;
`else
    assign wbuf_busy = 1'b0;
    assign post_en   = 1'b0;
`endif

    mem_wait_cnt u_wait_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (WAIT_LOAD),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        bad_d     = bad_q;
        wr_d      = wr_q;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        mem_wr_d  = 1'b0;
        cnt_load  = 1'b0;
        post_wr   = 1'b0;
        cpu_stall = 1'b0;

        case (state_q)
            IDLE: begin
                cpu_stall = cpu_req;
                if (cpu_req && !wbuf_busy) begin
                    addr_d  = cpu_addr;
                    wr_d    = cpu_wr;
                    wdata_d = cpu_wdata;
                    if (is_misaligned(cpu_addr)) begin
                        state_d = ERR;
                    end else begin
                        cnt_load = 1'b1;
                        mem_wr_d = cpu_wr;
                        post_wr  = post_en && cpu_wr;
                        // A posted write completes to the CPU at once; the buffer retires it.
                        ready_d  = post_wr;
                        state_d  = post_wr ? IDLE : ACCESS;
                    end
                end
            end
            ACCESS: begin
                cpu_stall = 1'b1;
                if (cnt_zero) begin
                    if (!wr_q) begin
                        rdata_d = mem_rdata;
                    end
                    ready_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            ERR: begin
                bad_d   = addr_q;
                ready_d = 1'b1;
                err_d   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            bad_q    <= '0;
            wr_q     <= 1'b0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            mem_wr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            bad_q    <= bad_d;
            wr_q     <= wr_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
            mem_wr_q <= mem_wr_d;
        end
    end

    assign cpu_rdata = rdata_q;
    assign cpu_ready = ready_q;
    assign cpu_err   = err_q;
    assign bad_addr  = bad_q;
    assign mem_addr  = addr_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: two instances (WAIT_CYCLES=2 and 0),
// directed scenarios followed by randomized transactions against a latency model.
module tb_mem_ctrl;

    localparam int W0 = 2;
    localparam int W1 = 0;
    localparam int TIMEOUT = 40;

    logic        clock = 1'b0;
    logic        reset;
    logic        req    [2];
    logic        wr     [2];
    logic [31:0] addr   [2];
    logic [31:0] wdata  [2];
    logic [31:0] mrdata [2];
    logic [31:0] rdata  [2];
    logic [31:0] bad    [2];
    logic [31:0] maddr  [2];
    logic [31:0] mwdata [2];
    logic        rdy    [2];
    logic        stall  [2];
    logic        err    [2];
    logic        mwr    [2];

    int          passed = 0;
    int          total  = 0;
    logic [31:0] exp_rdata [2];
    logic [31:0] exp_bad   [2];

    always #5 clock = ~clock;

    mem_ctrl #(.WAIT_CYCLES(W0)) u_dut0 (
        .clock(clock), .reset(reset),
        .cpu_req(req[0]), .cpu_wr(wr[0]), .cpu_addr(addr[0]), .cpu_wdata(wdata[0]),
        .cpu_rdata(rdata[0]), .cpu_ready(rdy[0]), .cpu_stall(stall[0]), .cpu_err(err[0]),
        .bad_addr(bad[0]), .mem_addr(maddr[0]), .mem_wr(mwr[0]), .mem_wdata(mwdata[0]),
        .mem_rdata(mrdata[0])
    );

    mem_ctrl #(.WAIT_CYCLES(W1)) u_dut1 (
        .clock(clock), .reset(reset),
        .cpu_req(req[1]), .cpu_wr(wr[1]), .cpu_addr(addr[1]), .cpu_wdata(wdata[1]),
        .cpu_rdata(rdata[1]), .cpu_ready(rdy[1]), .cpu_stall(stall[1]), .cpu_err(err[1]),
        .bad_addr(bad[1]), .mem_addr(maddr[1]), .mem_wr(mwr[1]), .mem_wdata(mwdata[1]),
        .mem_rdata(mrdata[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic check_reset_state(input int d, input string tag);
        check({tag, " cpu_ready"}, 32'(rdy[d]), 32'd0);
        check({tag, " cpu_err"},   32'(err[d]), 32'd0);
        check({tag, " cpu_stall"}, 32'(stall[d]), 32'd0);
        check({tag, " mem_wr"},    32'(mwr[d]), 32'd0);
        check({tag, " cpu_rdata"}, rdata[d], 32'd0);
        check({tag, " bad_addr"},  bad[d], 32'd0);
        check({tag, " mem_addr"},  maddr[d], 32'd0);
    endtask

    // One CPU access: drive at a negedge, observe each cycle at the negedge,
    // drop cpu_req in the ready cycle, then idle for gap cycles.
    task automatic do_txn(input int d, input logic wr_b, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] mr,
                          input int gap, input string tag);
        int   wc;
        int   k;
        int   nwr;
        int   exp_lat;
        logic misal;
        logic posted;
        logic seen;
        logic stall_ok;
        logic addr_ok;
        logic exp_stall;

        wc       = (d == 0) ? W0 : W1;
        misal    = (a % 4) != 0;
        posted   = 1'b0;
`ifdef MEM_CTRL_WBUF_EN
        posted   = wr_b && !misal;
`endif
        exp_lat  = misal ? 2 : (posted ? 1 : 2 + wc);
        exp_stall = !misal && !posted;
        k        = 0;
        nwr      = 0;
        seen     = 1'b0;
        stall_ok = 1'b1;
        addr_ok  = 1'b1;

        req[d]    = 1'b1;
        wr[d]     = wr_b;
        addr[d]   = a;
        wdata[d]  = wd;
        mrdata[d] = mr;
        #1;
        if (stall[d] !== 1'b1) stall_ok = 1'b0;
        if (mwr[d] === 1'b1) nwr++;

        while (k < TIMEOUT && !seen) begin
            @(negedge clock);
            k++;
            // Inputs other than cpu_req must be ignored once the access is accepted.
            wr[d]    = ~wr_b;
            addr[d]  = $urandom;
            wdata[d] = $urandom;
            if (mwr[d] === 1'b1) begin
                nwr++;
                check({tag, " mem_wr addr"}, maddr[d], a);
                check({tag, " mem_wr data"}, mwdata[d], wd);
            end
            if (rdy[d] === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (stall[d] !== exp_stall) stall_ok = 1'b0;
                if (exp_stall && maddr[d] !== a) addr_ok = 1'b0;
            end
        end

        req[d] = 1'b0;
        if (!misal && !wr_b) exp_rdata[d] = mr;
        if (misal) exp_bad[d] = a;

        check({tag, " ready seen"}, 32'(seen), 32'd1);
        check({tag, " latency"},    32'(k), 32'(exp_lat));
        check({tag, " cpu_err"},    32'(err[d]), 32'(misal));
        check({tag, " stall"},      32'(stall_ok), 32'd1);
        check({tag, " addr held"},  32'(addr_ok), 32'd1);
        check({tag, " cpu_rdata"},  rdata[d], exp_rdata[d]);
        check({tag, " bad_addr"},   bad[d], exp_bad[d]);
        check({tag, " mem_wr cnt"}, 32'(nwr), 32'(wr_b && !misal));
        $display("txn dut%0d %-8s wr=%0b addr=%08h wdata=%08h lat=%0d err=%0b rdata=%08h",
                 d, tag, wr_b, a, wd, k, err[d], rdata[d]);

        mrdata[d] = $urandom;
        @(negedge clock);
        check({tag, " ready pulse"}, 32'(rdy[d]), 32'd0);
        check({tag, " rdata held"},  rdata[d], exp_rdata[d]);
        for (int g = 1; g < gap; g++) @(negedge clock);
        if (posted) repeat (wc) @(negedge clock);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] lo;
        int          d;

        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0; mrdata[i] = '0;
            exp_rdata[i] = '0; exp_bad[i] = '0;
        end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_reset_state(0, "rst0");
        check_reset_state(1, "rst1");

        do_txn(0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1, "rd");
        do_txn(0, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'hA5A5_A5A5, 1, "wr");
        do_txn(0, 1'b0, 32'h0000_0013, 32'h0, 32'h0BAD_F00D, 2, "misal");

        // Reset during the second ACCESS cycle aborts the read.
        req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h0000_0040; mrdata[0] = 32'hCAFE_0001;
        @(negedge clock);
        check("abort mem_addr", maddr[0], 32'h0000_0040);
        @(negedge clock);
        reset = 1'b1;
        req[0] = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        exp_rdata[0] = '0; exp_bad[0] = '0; exp_rdata[1] = '0; exp_bad[1] = '0;
        check_reset_state(0, "abort");
        begin
            int pulses = 0;
            repeat (4) begin
                @(negedge clock);
                if (rdy[0] === 1'b1) pulses++;
            end
            check("abort no ready", 32'(pulses), 32'd0);
        end

        do_txn(1, 1'b0, 32'h0000_0000, 32'h0, 32'h1111_2222, 1, "b2b0");
        do_txn(1, 1'b0, 32'h0000_0004, 32'h0, 32'h3333_4444, 1, "b2b1");
        do_txn(1, 1'b1, 32'h0000_0008, 32'h5555_6666, 32'h7777_8888, 1, "wr0");
        do_txn(0, 1'b1, 32'h0000_0030, 32'h9999_AAAA, 32'hBBBB_CCCC, 1, "wr_rd0");
        do_txn(0, 1'b0, 32'h0000_0034, 32'h0, 32'hDDDD_EEEE, 1, "wr_rd1");

        for (int i = 0; i < 40; i++) begin
            d  = int'($urandom_range(0, 1));
            ra = $urandom;
            lo = $urandom_range(1, 3);
            ra = {ra[31:2], 2'b00};
            if ($urandom_range(0, 3) == 0) ra = ra | lo;
            do_txn(d, 1'($urandom_range(0, 1)), ra, $urandom, $urandom,
                   int'($urandom_range(1, 3)), "rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
